// File: rtl/sad_image_loader.sv
// sad_image_loader
// Streams UART pixel bytes into the search-image RAM in raster order.
// A frame load starts (or restarts) on UARTstart. The block raises
// FIFOready once the last pixel is written. It flags loadError when the
// gap between bytes grows too long. It keeps a 16-bit running byte sum of
// the bytes accepted so the host can check the frame.
module sad_image_loader #(
   parameter int IMG_ROWS       = 480,
   parameter int IMG_COLS       = 40,
   parameter int TIMEOUT_CYCLES = 10000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        UARTstart,
   input  logic        rxValid,
   input  logic [7:0]  rxData,
   output logic        ramWriteEnable,
   output logic [8:0]  ramWriteRow,
   output logic [5:0]  ramWriteCol,
   output logic [7:0]  ramWriteData,
   output logic        FIFOready,
   output logic        loadError,
   output logic        busy,
   output logic [15:0] checksum
);

   // Last valid counter values, at full counter width.
   localparam logic [8:0]  ROW_LAST = 9'(IMG_ROWS - 1);
   localparam logic [5:0]  COL_LAST = 6'(IMG_COLS - 1);
   localparam logic [23:0] GAP_LAST = 24'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic [8:0]   row_q, row_d;
   logic [5:0]   col_q, col_d;
   logic [23:0]  gap_q, gap_d;
   logic [15:0]  checksum_q, checksum_d;
   logic         we_q, we_d;
   logic [8:0]   wr_row_q, wr_row_d;
   logic [5:0]   wr_col_q, wr_col_d;
   logic [7:0]   wr_data_q, wr_data_d;
   logic         fifo_ready_q, fifo_ready_d;
   logic         load_error_q, load_error_d;
   logic         busy_q, busy_d;

   // Next-state, address advance, checksum and timeout decisions.
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      gap_d        = gap_q;
      checksum_d   = checksum_q;
      we_d         = 1'b0;
      wr_row_d     = wr_row_q;
      wr_col_d     = wr_col_q;
      wr_data_d    = wr_data_q;
      fifo_ready_d = fifo_ready_q;
      load_error_d = load_error_q;

      if (UARTstart) begin
         // Start always wins, even over a byte arriving in the same cycle.
         state_d      = S_LOAD;
         row_d        = 9'd0;
         col_d        = 6'd0;
         gap_d        = 24'd0;
         checksum_d   = 16'd0;
         fifo_ready_d = 1'b0;
         load_error_d = 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (rxValid) begin
                  we_d       = 1'b1;
                  wr_row_d   = row_q;
                  wr_col_d   = col_q;
                  wr_data_d  = rxData;
                  checksum_d = checksum_q + {8'd0, rxData};
                  gap_d      = 24'd0;
                  if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                     // Counters hold at the last address while DONE.
                     state_d      = S_DONE;
                     fifo_ready_d = 1'b1;
                  end else if (col_q == COL_LAST) begin
                     col_d = 6'd0;
                     row_d = row_q + 9'd1;
                  end else begin
                     col_d = col_q + 6'd1;
                  end
               end else if (gap_q == GAP_LAST) begin
                  state_d      = S_ERROR;
                  load_error_d = 1'b1;
               end else begin
                  gap_d = gap_q + 24'd1;
               end
            end
            S_IDLE, S_DONE, S_ERROR: begin
               // Bytes are ignored here; only UARTstart leaves these states.
               state_d = state_q;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d == S_LOAD);
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         row_q        <= 9'd0;
         col_q        <= 6'd0;
         gap_q        <= 24'd0;
         checksum_q   <= 16'd0;
         we_q         <= 1'b0;
         wr_row_q     <= 9'd0;
         wr_col_q     <= 6'd0;
         wr_data_q    <= 8'd0;
         fifo_ready_q <= 1'b0;
         load_error_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         gap_q        <= gap_d;
         checksum_q   <= checksum_d;
         we_q         <= we_d;
         wr_row_q     <= wr_row_d;
         wr_col_q     <= wr_col_d;
         wr_data_q    <= wr_data_d;
         fifo_ready_q <= fifo_ready_d;
         load_error_q <= load_error_d;
         busy_q       <= busy_d;
      end
   end

   assign ramWriteEnable = we_q;
   assign ramWriteRow    = wr_row_q;
   assign ramWriteCol    = wr_col_q;
   assign ramWriteData   = wr_data_q;
   assign FIFOready      = fifo_ready_q;
   assign loadError      = load_error_q;
   assign busy           = busy_q;
   assign checksum       = checksum_q;

endmodule

// File: tb/tb_sad_image_loader.sv
// Scoreboard bench for sad_image_loader (3x4 image, 20-cycle byte timeout).
module tb_sad_image_loader;

   logic        clock;
   logic        reset;
   logic        UARTstart;
   logic        rxValid;
   logic [7:0]  rxData;
   logic        ramWriteEnable;
   logic [8:0]  ramWriteRow;
   logic [5:0]  ramWriteCol;
   logic [7:0]  ramWriteData;
   logic        FIFOready;
   logic        loadError;
   logic        busy;
   logic [15:0] checksum;

   sad_image_loader #(
      .IMG_ROWS(3),
      .IMG_COLS(4),
      .TIMEOUT_CYCLES(20)
   ) dut (
      .clock(clock),
      .reset(reset),
      .UARTstart(UARTstart),
      .rxValid(rxValid),
      .rxData(rxData),
      .ramWriteEnable(ramWriteEnable),
      .ramWriteRow(ramWriteRow),
      .ramWriteCol(ramWriteCol),
      .ramWriteData(ramWriteData),
      .FIFOready(FIFOready),
      .loadError(loadError),
      .busy(busy),
      .checksum(checksum)
   );

   typedef struct {
      logic [8:0] row;
      logic [5:0] col;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [8:0]  mrow;
   logic [5:0]  mcol;
   logic [15:0] msum;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Cycle index used to check the one-cycle write latency.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Write monitor: every strobe must match the oldest expected write.
   always @(negedge clock) begin
      if (ramWriteEnable === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_write", 32'(ramWriteEnable), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("wr_row",   32'(ramWriteRow),  32'(e.row));
            check("wr_col",   32'(ramWriteCol),  32'(e.col));
            check("wr_data",  32'(ramWriteData), 32'(e.data));
            check("wr_cycle", 32'(cyc),          32'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_frame();
      UARTstart = 1'b1;
      tick();
      UARTstart = 1'b0;
      mrow = 9'd0;
      mcol = 6'd0;
      msum = 16'd0;
   endtask

   // Drive one byte; when accept is set the bench expects a write for it.
   task automatic send_byte(input logic [7:0] d, input logic accept);
      exp_t e;
      rxValid = 1'b1;
      rxData  = d;
      if (accept) begin
         e.row  = mrow;
         e.col  = mcol;
         e.data = d;
         e.cyc  = cyc + 1;
         sb_q.push_back(e);
         msum = msum + {8'd0, d};
         if (mcol == 6'd3) begin
            mcol = 6'd0;
            mrow = mrow + 9'd1;
         end else begin
            mcol = mcol + 6'd1;
         end
      end
      tick();
      rxValid = 1'b0;
   endtask

   task automatic drain();
      @(negedge clock);
      #1;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      logic lerr_early;
      reset     = 1'b1;
      UARTstart = 1'b0;
      rxValid   = 1'b0;
      rxData    = 8'd0;
      mrow = 9'd0; mcol = 6'd0; msum = 16'd0;
      #12;
      check("rst_we",   32'(ramWriteEnable), 32'd0);
      check("rst_fifo", 32'(FIFOready), 32'd0);
      check("rst_err",  32'(loadError), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum",  32'(checksum), 32'd0);
      check("rst_addr", 32'({ramWriteRow, ramWriteCol}), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Full load with idle gaps.
      start_frame();
      check("full_busy", 32'(busy), 32'd1);
      for (int i = 1; i <= 12; i++) begin
         if (i == 12) check("full_fifo_pre", 32'(FIFOready), 32'd0);
         send_byte(8'(i), 1'b1);
         if (i < 12) begin
            tick();
            tick();
         end
      end
      check("full_fifo", 32'(FIFOready), 32'd1);
      check("full_sum",  32'(checksum), 32'h004E);
      check("full_model_sum", 32'(msum), 32'(checksum));
      check("full_busy_after", 32'(busy), 32'd0);
      drain();

      // Back-to-back bytes of 0xFF.
      start_frame();
      for (int i = 0; i < 12; i++) send_byte(8'hFF, 1'b1);
      check("b2b_fifo", 32'(FIFOready), 32'd1);
      check("b2b_sum",  32'(checksum), 32'h0BF4);
      drain();

      // DONE hold, then reload.
      for (int i = 0; i < 3; i++) begin
         send_byte(8'h55, 1'b0);
         tick();
      end
      check("done_fifo", 32'(FIFOready), 32'd1);
      check("done_sum",  32'(checksum), 32'h0BF4);
      start_frame();
      check("reload_fifo", 32'(FIFOready), 32'd0);
      check("reload_busy", 32'(busy), 32'd1);
      check("reload_sum",  32'(checksum), 32'd0);

      // Timeout after 5 bytes.
      start_frame();
      for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1);
      lerr_early = 1'b0;
      for (int k = 1; k <= 19; k++) begin
         tick();
         if (loadError) lerr_early = 1'b1;
      end
      check("to_early", 32'(lerr_early), 32'd0);
      tick();
      check("to_err",  32'(loadError), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      send_byte(8'h77, 1'b0);
      send_byte(8'h78, 1'b0);
      tick();
      check("to_sum",  32'(checksum), 32'h005A);
      check("to_hold", 32'(loadError), 32'd1);
      drain();

      // Restart mid-frame with a coincident byte.
      start_frame();
      check("rs_err_clr", 32'(loadError), 32'd0);
      for (int i = 0; i < 7; i++) send_byte(8'(8'h21 + i), 1'b1);
      UARTstart = 1'b1;
      rxValid   = 1'b1;
      rxData    = 8'h99;
      tick();
      UARTstart = 1'b0;
      rxValid   = 1'b0;
      mrow = 9'd0; mcol = 6'd0; msum = 16'd0;
      check("rs_busy", 32'(busy), 32'd1);
      check("rs_sum0", 32'(checksum), 32'd0);
      send_byte(8'h42, 1'b1);
      check("rs_sum",  32'(checksum), 32'h0042);
      drain();

      // Asynchronous reset in the middle of a load.
      start_frame();
      for (int i = 0; i < 3; i++) send_byte(8'h30, 1'b1);
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_sum",  32'(checksum), 32'd0);
      check("ar_fifo", 32'(FIFOready), 32'd0);
      check("ar_addr", 32'({ramWriteRow, ramWriteCol, ramWriteData}), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      send_byte(8'h11, 1'b0);
      send_byte(8'h12, 1'b0);
      tick();
      check("ar_idle_sum",  32'(checksum), 32'd0);
      check("ar_idle_busy", 32'(busy), 32'd0);
      start_frame();
      send_byte(8'h13, 1'b1);
      check("ar_new_sum", 32'(checksum), 32'h0013);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
